// File: rtl/dead_time_gen_pkg.sv
// Shared control-stage definitions: config bus addresses and the dead-time FSM state type.
package dead_time_gen_pkg;

  localparam logic [3:0] REF_GEN_ADDR   = 4'd0;
  localparam logic [3:0] PRED_ADDR      = 4'd1;
  localparam logic [3:0] FREQ_ADDR      = 4'd2;
  localparam logic [3:0] PW_ADDR        = 4'd3;
  localparam logic [3:0] OCD_ADDR       = 4'd4;
  localparam logic [3:0] DEAD_TIME_ADDR = 4'd5;

  typedef enum logic [1:0] {IDLE, DEAD, ON_P, ON_N} dt_state_t;

endpackage

// File: rtl/dead_time_gen.sv
// Complementary H-bridge gate driver with programmable dead time and overcurrent shutdown.
// Define DEAD_TIME_FAULT_LATCH_EN to hold the fault until reset instead of following ocd.
module dead_time_gen
  import dead_time_gen_pkg::*;
#(
  parameter int                  DATA_W     = 8,
  parameter int                  ADDR_MAX   = 4,
  parameter logic [ADDR_MAX-1:0] ADDR       = ADDR_MAX'(DEAD_TIME_ADDR),
  parameter logic [DATA_W-1:0]   DT_DEFAULT = DATA_W'(10),
  parameter logic [DATA_W-1:0]   DT_MIN     = DATA_W'(2)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                in,
  input  logic                gate_en,
  input  logic                ocd,
  input  logic [DATA_W-1:0]   data,
  input  logic [ADDR_MAX-1:0] addr,
  input  logic                en,
  output logic                out_p,
  output logic                out_n,
  output logic                fault
);

  dt_state_t         state, state_nx;
  logic [DATA_W-1:0] dt_reg, cnt, cnt_nx;
  logic              target, target_nx;
  logic              fault_cond, cfg_wr, fault_nx;

  assign fault_cond = ocd | fault;
  assign cfg_wr     = en && (addr == ADDR);

`ifdef DEAD_TIME_FAULT_LATCH_EN
  assign fault_nx = fault | ocd;
`else
  assign fault_nx = ocd;
`endif

  // target holds the side currently commanded; in ON_P/ON_N it equals the driven side,
  // so a mismatch with in is the polarity change that must go back through DEAD.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    target_nx = target;
    if (fault_cond || !gate_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nx  = DEAD;
          cnt_nx    = dt_reg;
          target_nx = in;
        end
        DEAD: begin
          target_nx = in;
          cnt_nx    = cnt - DATA_W'(1);
          if (cnt == DATA_W'(1)) state_nx = in ? ON_P : ON_N;
        end
        ON_P, ON_N: begin
          if (in != target) begin
            state_nx  = DEAD;
            cnt_nx    = dt_reg;
            target_nx = in;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= 1'b0;
      fault  <= 1'b0;
      dt_reg <= DT_DEFAULT;
      out_p  <= 1'b0;
      out_n  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      target <= target_nx;
      fault  <= fault_nx;
      // Gate outputs are flops mirroring the next state so they never glitch.
      out_p  <= (state_nx == ON_P);
      out_n  <= (state_nx == ON_N);
      if (cfg_wr) dt_reg <= (data < DT_MIN) ? DT_MIN : data;
    end
  end

endmodule

// File: tb/tb_dead_time_gen.sv
// Bench for dead_time_gen: directed dead-time scenarios plus randomized traffic against a cycle-count model.
module tb_dead_time_gen;
  import dead_time_gen_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, in = 1'b0, gate_en = 1'b0, ocd = 1'b0, en = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] addr = '0;
  logic       out_p, out_n, fault;
  int         total = 0, bad = 0;

`ifdef DEAD_TIME_FAULT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  dead_time_gen dut (
    .clk(clk), .rst(rst), .in(in), .gate_en(gate_en), .ocd(ocd),
    .data(data), .addr(addr), .en(en),
    .out_p(out_p), .out_n(out_n), .fault(fault)
  );

  always #5 clk = ~clk;

  // Model: drive = side on (0 none, 1 P, 2 N); dead_until = cycle number at which the
  // current both-low interval ends (-1 when not in one). Gate turns on dt cycles after start.
  int cyc = 0, drive = 0, dead_until = -1, mdt = 10;
  bit mflt = 1'b0, mvalid = 1'b0, fc;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      drive = 0; dead_until = -1; mflt = 1'b0; mdt = 10; mvalid = 1'b1;
    end else begin
      fc = ocd || mflt;
      if (fc || !gate_en) begin
        drive = 0; dead_until = -1;
      end else if (dead_until >= 0) begin
        if (cyc == dead_until) begin drive = in ? 1 : 2; dead_until = -1; end
      end else if (drive == 0 || (drive == 1 && !in) || (drive == 2 && in)) begin
        drive = 0; dead_until = cyc + mdt;
      end
      mflt = LATCH ? (mflt || ocd) : ocd;
      if (en && addr == DEAD_TIME_ADDR) mdt = (data < 2) ? 2 : int'(data);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      total++;
      if (out_p !== (drive == 1) || out_n !== (drive == 2) || fault !== mflt || (out_p && out_n)) begin
        bad++;
        $display("FAIL model_cmp cyc=%0d got p=%b n=%b f=%b want p=%0b n=%0b f=%0b",
                 cyc, out_p, out_n, fault, drive == 1, drive == 2, mflt);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Counts edges after which both gates are still low, stopping at the first gate-on.
  task automatic measure_low(output int n);
    n = 0;
    repeat (64) begin
      tick();
      if (out_p || out_n) return;
      n++;
    end
  endtask

  task automatic cfg_write(input logic [7:0] d);
    en = 1'b1; addr = DEAD_TIME_ADDR; data = d;
    tick();
    en = 1'b0; addr = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    lit("reset_p", out_p, 0); lit("reset_n", out_n, 0); lit("reset_fault", fault, 0);

    // Power-up: default dead time then P side.
    gate_en = 1'b1; in = 1'b1;
    measure_low(n); lit("dt_default", n, 10); lit("first_on_p", out_p, 1);

    // Dead time 4 on a P->N change.
    cfg_write(8'd4);
    in = 1'b0;
    measure_low(n); lit("dt4_low", n, 4); lit("dt4_on_n", out_n, 1);

    // Programmed 0 clamps to 2 in both directions.
    cfg_write(8'd0);
    in = 1'b1;
    measure_low(n); lit("dt_clamp_pn", n, 2); lit("clamp_on_p", out_p, 1);
    in = 1'b0;
    measure_low(n); lit("dt_clamp_np", n, 2); lit("clamp_on_n", out_n, 1);

    // Toggling in during DEAD does not restart the count; final in picks the side.
    cfg_write(8'd10);
    in = 1'b1; tick();
    in = 1'b0; tick();
    in = 1'b1; tick();
    in = 1'b0; tick();
    measure_low(n); lit("dead_no_restart", n + 4, 10); lit("final_side_n", out_n, 1);

    // One-cycle overcurrent while driving N.
    ocd = 1'b1; tick(); ocd = 1'b0;
    lit("ocd_n_low", out_n, 0); lit("ocd_fault", fault, 1);
    if (LATCH) begin
      repeat (20) tick();
      lit("latch_idle_p", out_p, 0); lit("latch_idle_n", out_n, 0); lit("latch_fault", fault, 1);
    end else begin
      measure_low(n); lit("ocd_resume_low", n, 11); lit("ocd_resume_n", out_n, 1);
      lit("ocd_fault_clear", fault, 0);
    end

    // gate_en blip in ON_P forces a full dead interval.
    rst = 1'b1; tick(); rst = 1'b0;
    in = 1'b1; gate_en = 1'b1;
    measure_low(n); lit("rst_dt_default", n, 10);
    gate_en = 1'b0; tick(); lit("gate_off_p", out_p, 0);
    gate_en = 1'b1;
    measure_low(n); lit("regate_dead", n, 10); lit("regate_on_p", out_p, 1);

    // Randomized traffic, including mid-run resets, faults and config writes.
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, LATCH ? 99 : 499) == 0);
      ocd     = ($urandom_range(0, 199) == 0);
      gate_en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 9) == 0) in = ~in;
      en      = ($urandom_range(0, 29) == 0);
      addr    = 4'($urandom_range(4, 6));
      data    = 8'($urandom_range(0, 14));
      tick();
    end
    rst = 1'b0; ocd = 1'b0; en = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
